shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential shift-add multiplier: product = multiplicand * multiplier + addend, one multiplier bit per cycle.
- It is the inverse of the restoring divider. Feeding it divisor, quotient and remainder rebuilds the dividend, so the same module is used as the divider's self-check and round-trip partner.
- Control FSM and datapath live in one module, with a start/done handshake like the divider's.

Parameters:
- WIDTH, 4, operand width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request; accepted only in IDLE
- multiplicand  input  WIDTH  unsigned operand (divisor in round-trip use)
- multiplier  input  WIDTH  unsigned operand (quotient in round-trip use)
- addend  input  WIDTH+1  unsigned value added to the product (remainder in round-trip use)
- product  output  2*WIDTH+1  result register
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - state to IDLE
  - product, busy, done to 0
  - accumulator A, shift registers M and Q, and count to 0
- Reset mid-operation aborts the operation with no output side effects; the result is lost.
- States are IDLE, CALC and DONE.
- IDLE:
  - A rising edge with start=1 captures the inputs: A <= zero-extended addend; M <= zero-extended multiplicand (2*WIDTH+1 bits); Q <= multiplier; count <= 0.
  - Next state is CALC.
  - start=0 keeps the block in IDLE.
- CALC, every cycle:
  - if Q[0] then A <= A + M (the width 2*WIDTH+1 never overflows, since the maximum is (2^W-1)^2 + 2^(W+1)-1)
  - M <= M << 1; Q <= Q >> 1; count <= count + 1
  - Next state is DONE when count == WIDTH-1, else stay in CALC.
- DONE:
  - product <= final A (the A value including the last CALC add); done = 1 for exactly this one cycle.
  - Next state is IDLE.
- Latency: the edge that accepts start is cycle 0. done is high during cycle WIDTH+1; product is valid from that cycle.
- product holds its value until the DONE state of the next accepted operation. It does not change when start is accepted.
- start while busy (CALC or DONE) is ignored, with no queuing. start held high continuously starts a new operation on the first IDLE edge after DONE, one idle cycle between operations.
- Operand changes after acceptance have no effect.
- count is $clog2(WIDTH) bits wide, with a minimum of 1 bit.

Optional Feature:
- Macro: SHIFT_ADD_MULT_EARLY_TERM_EN.
- Defined: in CALC, the next state is DONE when count == WIDTH-1 or (Q >> 1) == 0.
  - Latency becomes 1 + max(1, index of the highest set multiplier bit + 1) cycles.
  - multiplier=0 or 1 gives done at cycle 2.
  - The result is identical to the full run.
- Undefined: fixed latency of WIDTH+1 for all operands.

Test Plan:
- Reset release, idle 3 cycles -> product=0, done=0, busy=0.
- WIDTH=4, multiplicand=13, multiplier=11, addend=0, start pulse -> busy in cycles 1-5, done only in cycle 5, product=143.
- multiplicand=15, multiplier=15, addend=31 -> product=256 (bit 8 set, no overflow).
- Round trip: divider dividend=14, divisor=4 gives quotient=3, remainder=2. Feed multiplicand=4, multiplier=3, addend=2 -> product=14.
- Cases with a mid-operation event:
  - start re-pulsed in cycle 2 with new operands (2,2,0) -> ignored; product=143 at cycle 5 and only one done pulse.
  - rst=0 asserted in cycle 3 of a separate run -> product=0 and state IDLE immediately, with no done.
- multiplicand=9, multiplier=1, addend=5 -> product=14; done at cycle 2 with SHIFT_ADD_MULT_EARLY_TERM_EN defined, at cycle 5 without it.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: product = multiplicand * multiplier + addend.
// Optional SHIFT_ADD_MULT_EARLY_TERM_EN stops once the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH:0]     addend,
  output logic [2*WIDTH:0]   product,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    a_sum;
  logic             last;

  assign a_sum = a_q + (q_q[0] ? m_q : '0);

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  assign last = (cnt_q == CW'(WIDTH - 1))
             || (q_q[WIDTH-1:1] == '0);
`else
  assign last = (cnt_q == CW'(WIDTH - 1));
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {{WIDTH{1'b0}}, addend};
          m_d     = {{(WIDTH+1){1'b0}}, multiplicand};
          q_d     = multiplier;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_sum;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // load on DONE entry so product is valid while done is high
          prod_d  = a_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign product = prod_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Directed table, mid-operation corner cases and random ops vs an arithmetic model.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   mc;
  logic [W-1:0]   mp;
  logic [W:0]     ad;
  logic [2*W:0]   product;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  logic [2*W:0] prev_prod;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .addend       (ad),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] mc;
    logic [W-1:0] mp;
    logic [W:0]   ad;
    logic [2*W:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] m);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++)
      if (m[i]) h = i + 1;
    return 1 + ((h < 1) ? 1 : h);
`else
    return W + 1;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] c, input int repulse,
                        input string tag);
    int lat;
    int dc;
    int np;
    bit busy_ok;
    bit hold_ok;
    logic [2*W:0] exp;
    exp = (2*W+1)'(a) * (2*W+1)'(b) + (2*W+1)'(c);
    lat = exp_lat(b);
    dc = -1;
    np = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    mc = a;
    mp = b;
    ad = c;
    for (int cy = 1; cy <= W + 3; cy++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        np++;
        if (dc < 0) dc = cy;
      end
      if (busy !== (cy <= lat)) busy_ok = 1'b0;
      if (cy < lat && product !== prev_prod) hold_ok = 1'b0;
      if (cy == 1) start = 1'b0;
      if (cy == repulse) begin
        start = 1'b1;
        mc = 2;
        mp = 2;
        ad = 0;
      end
      if (repulse > 0 && cy == repulse + 1) start = 1'b0;
    end
    check({tag, "_done_cycle"}, dc, lat);
    check({tag, "_done_pulses"}, np, 1);
    check({tag, "_busy_window"}, busy_ok, 1);
    check({tag, "_product_hold"}, hold_ok, 1);
    check({tag, "_product"}, product, exp);
    prev_prod = exp;
  endtask

  initial begin
    int lat;
    int np;
    int d1;
    int d2;
    bit seen;

    tbl[0] = '{4'd13, 4'd11, 5'd0,  9'd143};
    tbl[1] = '{4'd15, 4'd15, 5'd31, 9'd256};
    tbl[2] = '{4'd4,  4'd3,  5'd2,  9'd14};
    tbl[3] = '{4'd9,  4'd1,  5'd5,  9'd14};
    tbl[4] = '{4'd7,  4'd0,  5'd9,  9'd9};
    tbl[5] = '{4'd0,  4'd15, 5'd0,  9'd0};

    rst = 1'b0;
    start = 1'b0;
    mc = '0;
    mp = '0;
    ad = '0;
    prev_prod = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_product", product, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].mc, tbl[i].mp, tbl[i].ad, 0, $sformatf("tbl%0d", i));

    run_op(4'd13, 4'd11, 5'd0, 2, "repulse");

    // Reset in cycle 3 of an operation
    @(negedge clk);
    start = 1'b1;
    mc = 7;
    mp = 5;
    ad = 3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_product", product, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    check("abort_product_after", product, 0);
    prev_prod = '0;

    // start held high: back-to-back ops with one idle cycle
    lat = exp_lat(4'd5);
    np = 0;
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    start = 1'b1;
    mc = 3;
    mp = 5;
    ad = 1;
    for (int cy = 1; cy <= 2 * lat + 3; cy++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        np++;
        if (d1 < 0) d1 = cy;
        else if (d2 < 0) d2 = cy;
      end
      if (cy == 2 * lat + 1) start = 1'b0;
    end
    check("hold_pulses", np, 2);
    check("hold_first_done", d1, lat);
    check("hold_second_done", d2, 2 * lat + 1);
    check("hold_product", product, 16);
    prev_prod = 9'd16;

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
             (W+1)'($urandom_range(0, 31)), 0, $sformatf("rnd%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
